adc_capture_mux_buf: RTL and testbench

- Parametrised multi-channel ADC snapshot buffer, the next generation of the fixed voltage/current capture-and-send block.
- Captures NCH synchronous ADC channels into on-chip memory when commanded, with optional decimation.
- Streams any one selected channel to the MCU over the existing level-strobe handshake.
- Sits between the ADC front-end and the MCU command/data bus; single clock domain.

---
 rtl/adc_capture_mux_buf_if.sv | 25 ++
 rtl/adc_capture_mux_buf.sv | 96 +++++++++
 tb/tb_adc_capture_mux_buf.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_mux_buf_if.sv
// adc_capture_mux_buf_if: ADC sample input, MCU command and readout handshake bundle
interface adc_capture_mux_buf_if #(
  parameter int NCH = 2,
  parameter int DW  = 16
);
  logic              sample_valid;
  logic [NCH*DW-1:0] sample_data;
  logic [15:0]       cmd;
  logic              cmd_valid;
  logic              rd_ack;
  logic [DW-1:0]     data_out;
  logic              data_rdy;
  logic              capture_done;
  logic              read_done;
  logic              busy;
  logic              cmd_err;
  modport master (
    output sample_valid, sample_data, cmd, cmd_valid, rd_ack,
    input  data_out, data_rdy, capture_done, read_done, busy, cmd_err
  );
  modport slave (
    input  sample_valid, sample_data, cmd, cmd_valid, rd_ack,
    output data_out, data_rdy, capture_done, read_done, busy, cmd_err
  );
endinterface

// File: rtl/adc_capture_mux_buf.sv
// adc_capture_mux_buf: NCH-channel ADC snapshot capture with decimation and per-channel MCU readout
module adc_capture_mux_buf #(
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int DEPTH = 2048
) (
  input logic clk,
  input logic rst,
  adc_capture_mux_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, DONE, FETCH, WAIT1, HOLD} state_t;
  state_t            state, nxt;
  logic [NCH*DW-1:0] mem [DEPTH];
  logic [NCH*DW-1:0] mem_q;
  logic [AW-1:0]     waddr, raddr;
  logic [7:0]        decim, dec_cnt, op, arg;
  logic [CW-1:0]     ch_sel;
  logic              ack_q;
  logic              in_read, abort, arm_ok, dec_ok, rd_ok, cmd_bad, wr, last_wr, ack_edge, adv, last_rd;
  assign op  = bus.cmd[7:0];
  assign arg = bus.cmd[15:8];
  // Only accepted commands override the running state; rejected ones just flag cmd_err
  always_comb begin
    in_read  = state inside {FETCH, WAIT1, HOLD};
    abort    = bus.cmd_valid && op == 8'hDD;
    arm_ok   = bus.cmd_valid && op == 8'hAA && !in_read;
    dec_ok   = bus.cmd_valid && op == 8'hBB && (state == IDLE || state == DONE);
    rd_ok    = bus.cmd_valid && op == 8'hCC && state == DONE && arg < 8'(NCH);
    cmd_bad  = bus.cmd_valid && ((op == 8'hAA && in_read) || (op == 8'hBB && !dec_ok) || (op == 8'hCC && !rd_ok));
    wr       = state == CAPTURE && bus.sample_valid && dec_cnt == 8'd0 && !abort && !arm_ok;
    last_wr  = wr && waddr == LAST;
    ack_edge = bus.rd_ack && !ack_q;
    adv      = state == HOLD && ack_edge && !abort;
    last_rd  = adv && raddr == LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_comb begin
    nxt = abort   ? IDLE    :
          arm_ok  ? CAPTURE :
          rd_ok   ? FETCH   :
          last_wr ? DONE    :
          state == FETCH ? WAIT1 :
          state == WAIT1 ? HOLD  :
          adv ? (last_rd ? DONE : FETCH) : state;
  end
  always_comb begin
    bus.busy = state == CAPTURE || in_read;
  end
  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= bus.sample_data;
    mem_q <= mem[raddr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out     <= '0;
      bus.data_rdy     <= 1'b0;
      bus.capture_done <= 1'b0;
      bus.read_done    <= 1'b0;
      bus.cmd_err      <= 1'b0;
      decim            <= '0;
      dec_cnt          <= '0;
      waddr            <= '0;
      raddr            <= '0;
      ch_sel           <= '0;
      ack_q            <= 1'b0;
    end else begin
      ack_q         <= bus.rd_ack;
      bus.cmd_err   <= cmd_bad;
      bus.read_done <= last_rd;
      if (dec_ok) decim <= arg;
      if (arm_ok) begin
        waddr   <= '0;
        dec_cnt <= '0;
      end else if (state == CAPTURE && bus.sample_valid && !abort) begin
        dec_cnt <= dec_cnt == decim ? 8'd0 : dec_cnt + 8'd1;
        if (wr) waddr <= waddr + 1'b1;
      end
      if (abort || arm_ok) bus.capture_done <= 1'b0;
      else if (last_wr)    bus.capture_done <= 1'b1;
      if (rd_ok) begin
        ch_sel <= arg[CW-1:0];
        raddr  <= '0;
      end else if (adv) begin
        raddr <= last_rd ? '0 : raddr + 1'b1;
      end
      if (state == WAIT1 && !abort) bus.data_out <= mem_q[int'(ch_sel)*DW +: DW];
      bus.data_rdy <= (state == WAIT1 && !abort) ? 1'b1 : (abort || adv) ? 1'b0 : bus.data_rdy;
    end
  end
endmodule

// File: tb/tb_adc_capture_mux_buf.sv
// tb_adc_capture_mux_buf: randomized scenarios checked against a snapshot model of the kept samples
module tb_adc_capture_mux_buf;
  localparam int NCH = 3, DW = 16, DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  adc_capture_mux_buf_if #(.NCH(NCH), .DW(DW)) bus ();
  adc_capture_mux_buf #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  int m_decim = 0;
  logic [DW-1:0] exp_mem [DEPTH][NCH];
  logic [DW-1:0] got [DEPTH];
  int lat [DEPTH];
  int rd_done_cnt, rd_done_at;
  bit arm_err, arm_busy, arm_rdy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] w);
    bus.cmd = w;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
  endtask

  // The snapshot holds sample i when i is a multiple of decim+1, until DEPTH are held
  task automatic capture(input int nsamp, input bit rnd);
    int kept = 0;
    logic [NCH*DW-1:0] d;
    logic [DW-1:0] v;
    send_cmd(16'h00AA);
    for (int i = 0; i < nsamp; i++) begin
      for (int k = 0; k < NCH; k++) begin
        v = rnd ? DW'($urandom) : DW'((k << 8) + i);
        d[k*DW +: DW] = v;
        if (i % (m_decim + 1) == 0 && kept < DEPTH) exp_mem[kept][k] = v;
      end
      if (i % (m_decim + 1) == 0) kept++;
      bus.sample_data = d;
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    step();
  endtask

  task automatic wait_rdy(output int l);
    l = 0;
    while (!bus.data_rdy && l < 20) begin
      step();
      l++;
    end
    if (!bus.data_rdy) l = -1;
  endtask

  task automatic ack_pulse(output bit rdd);
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
    rdd = bus.read_done;
  endtask

  task automatic read_channel(input int ch, input int arm_at);
    bit rdd;
    send_cmd({8'(ch), 8'hCC});
    rd_done_cnt = 0;
    rd_done_at = -1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_rdy(lat[i]);
      got[i] = bus.data_out;
      if (i == arm_at) begin
        send_cmd(16'h00AA);
        arm_err = bus.cmd_err;
        arm_busy = bus.busy;
        arm_rdy = bus.data_rdy;
      end
      ack_pulse(rdd);
      if (rdd) begin
        rd_done_cnt++;
        rd_done_at = i;
      end
    end
    step();
    if (bus.read_done) rd_done_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_decim = 0;
    total++;
    if ({bus.data_out, bus.data_rdy, bus.capture_done, bus.read_done, bus.busy, bus.cmd_err} !== '0)
      $display("FAIL reset_outputs got %h want 0", {bus.data_out, bus.data_rdy, bus.capture_done, bus.read_done, bus.busy, bus.cmd_err});
    else passed++;
  endtask

  task automatic test_capture_read();
    capture(DEPTH + 3, 1'b0);
    total++;
    if ({bus.capture_done, bus.busy} !== 2'b10) $display("FAIL cap_status got %b want 10", {bus.capture_done, bus.busy});
    else passed++;
    read_channel(2, -1);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got[i] !== DW'(16'h0200 + i)) $display("FAIL cap_data[%0d] got %h want %h", i, got[i], DW'(16'h0200 + i));
      else passed++;
      total++;
      if (lat[i] !== 2) $display("FAIL cap_lat[%0d] got %0d want 2", i, lat[i]);
      else passed++;
    end
    total++;
    if (rd_done_cnt !== 1 || rd_done_at !== DEPTH - 1) $display("FAIL cap_read_done got cnt %0d at %0d want 1 at %0d", rd_done_cnt, rd_done_at, DEPTH - 1);
    else passed++;
    total++;
    if ({bus.capture_done, bus.busy, bus.data_rdy} !== 3'b100) $display("FAIL cap_back_to_done got %b want 100", {bus.capture_done, bus.busy, bus.data_rdy});
    else passed++;
  endtask

  task automatic test_handshake();
    int l, rises;
    bit prev, rdd;
    send_cmd(16'h01CC);
    wait_rdy(l);
    total++;
    if (l !== 2 || bus.data_out !== exp_mem[0][1]) $display("FAIL hs_first got lat %0d data %h want lat 2 data %h", l, bus.data_out, exp_mem[0][1]);
    else passed++;
    rises = 0;
    prev = bus.data_rdy;
    bus.rd_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_rdy && !prev) rises++;
      prev = bus.data_rdy;
    end
    bus.rd_ack = 1'b0;
    total++;
    if (rises !== 1 || bus.data_out !== exp_mem[1][1] || !bus.data_rdy)
      $display("FAIL hs_held got rises %0d data %h rdy %b want 1 %h 1", rises, bus.data_out, bus.data_rdy, exp_mem[1][1]);
    else passed++;
    ack_pulse(rdd);
    step();
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
    step();
    step();
    total++;
    if (bus.data_out !== exp_mem[2][1] || !bus.data_rdy) $display("FAIL hs_ignored_edge got %h rdy %b want %h 1", bus.data_out, bus.data_rdy, exp_mem[2][1]);
    else passed++;
    ack_pulse(rdd);
    wait_rdy(l);
    total++;
    if (l !== 2 || bus.data_out !== exp_mem[3][1]) $display("FAIL hs_next got lat %0d data %h want 2 %h", l, bus.data_out, exp_mem[3][1]);
    else passed++;
    send_cmd(16'h00DD);
    total++;
    if ({bus.data_rdy, bus.busy, bus.capture_done} !== 3'b000 || bus.data_out !== exp_mem[3][1])
      $display("FAIL hs_abort got %b data %h want 000 %h", {bus.data_rdy, bus.busy, bus.capture_done}, bus.data_out, exp_mem[3][1]);
    else passed++;
  endtask

  task automatic test_decim();
    send_cmd(16'h03BB);
    m_decim = 3;
    total++;
    if (bus.cmd_err !== 1'b0) $display("FAIL decim_accept got %b want 0", bus.cmd_err);
    else passed++;
    capture(64, 1'b0);
    total++;
    if (bus.capture_done !== 1'b1) $display("FAIL decim_done got %b want 1", bus.capture_done);
    else passed++;
    read_channel(0, -1);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got[i] !== DW'(4 * i)) $display("FAIL decim_data[%0d] got %h want %h", i, got[i], DW'(4 * i));
      else passed++;
    end
  endtask

  task automatic test_illegal();
    send_cmd(16'h03CC);
    total++;
    if ({bus.cmd_err, bus.busy} !== 2'b10) $display("FAIL ill_bad_ch got %b want 10", {bus.cmd_err, bus.busy});
    else passed++;
    step();
    total++;
    if (bus.cmd_err !== 1'b0) $display("FAIL ill_err_pulse got %b want 0", bus.cmd_err);
    else passed++;
    send_cmd(16'h00DD);
    send_cmd(16'h00CC);
    total++;
    if ({bus.cmd_err, bus.busy} !== 2'b10) $display("FAIL ill_read_idle got %b want 10", {bus.cmd_err, bus.busy});
    else passed++;
    send_cmd(16'h00BB);
    m_decim = 0;
    send_cmd(16'h00AA);
    send_cmd(16'h05BB);
    total++;
    if ({bus.cmd_err, bus.busy} !== 2'b11) $display("FAIL ill_decim_capture got %b want 11", {bus.cmd_err, bus.busy});
    else passed++;
    capture(DEPTH, 1'b1);
    read_channel(1, 5);
    total++;
    if ({arm_err, arm_busy, arm_rdy} !== 3'b111) $display("FAIL ill_arm_in_read got %b want 111", {arm_err, arm_busy, arm_rdy});
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got[i] !== exp_mem[i][1]) $display("FAIL ill_read_data[%0d] got %h want %h", i, got[i], exp_mem[i][1]);
      else passed++;
    end
  endtask

  task automatic test_abort();
    send_cmd(16'h00AA);
    for (int i = 0; i < 5; i++) begin
      bus.sample_data = {NCH*DW{1'b1}};
      bus.sample_valid = 1'b1;
      step();
    end
    send_cmd(16'h00DD);
    bus.sample_valid = 1'b0;
    total++;
    if ({bus.busy, bus.capture_done} !== 2'b00) $display("FAIL abort_state got %b want 00", {bus.busy, bus.capture_done});
    else passed++;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.sample_valid = 1'b0;
    total++;
    if ({bus.busy, bus.capture_done} !== 2'b00) $display("FAIL abort_idle_samples got %b want 00", {bus.busy, bus.capture_done});
    else passed++;
    send_cmd(16'h00CC);
    total++;
    if (bus.cmd_err !== 1'b1) $display("FAIL abort_read got %b want 1", bus.cmd_err);
    else passed++;
  endtask

  task automatic test_rst_mid_read();
    int l;
    bit rdd;
    capture(DEPTH, 1'b1);
    send_cmd(16'h02BB);
    send_cmd(16'h00CC);
    for (int i = 0; i < 7; i++) begin
      wait_rdy(l);
      ack_pulse(rdd);
    end
    wait_rdy(l);
    total++;
    if (bus.data_out !== exp_mem[7][0]) $display("FAIL rst_pre_data got %h want %h", bus.data_out, exp_mem[7][0]);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_decim = 0;
    total++;
    if ({bus.data_out, bus.data_rdy, bus.capture_done, bus.read_done, bus.busy, bus.cmd_err} !== '0)
      $display("FAIL rst_mid_read got %h want 0", {bus.data_out, bus.data_rdy, bus.capture_done, bus.read_done, bus.busy, bus.cmd_err});
    else passed++;
    capture(DEPTH, 1'b1);
    read_channel(2, -1);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (got[i] !== exp_mem[i][2]) $display("FAIL rst_reread[%0d] got %h want %h", i, got[i], exp_mem[i][2]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int d, ch;
    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(0, 3);
      ch = $urandom_range(0, NCH - 1);
      send_cmd({8'(d), 8'hBB});
      m_decim = d;
      capture(DEPTH * (d + 1) + 2, 1'b1);
      read_channel(ch, -1);
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (got[i] !== exp_mem[i][ch]) $display("FAIL rand%0d_ch%0d[%0d] got %h want %h", it, ch, i, got[i], exp_mem[i][ch]);
        else passed++;
      end
      total++;
      if (rd_done_cnt !== 1) $display("FAIL rand%0d_read_done got %0d want 1", it, rd_done_cnt);
      else passed++;
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    bus.rd_ack = 1'b0;
    test_reset();
    test_capture_read();
    test_handshake();
    test_decim();
    test_illegal();
    test_abort();
    test_rst_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
